// File: rtl/sha3_sequencer_if.sv
// Host/core-facing signal bundle for the SHA-3 block sequencer.
interface sha3_sequencer_if #(
    parameter int WORD_W = 136
);
    logic              start;
    logic              msg_valid;
    logic [WORD_W-1:0] msg_data;
    logic              msg_last;
    logic              msg_ready;
    logic              load_en;
    logic [WORD_W-1:0] load_data;
    logic              core_init;
    logic              core_enable;
    logic              core_complete;
    logic              digest_valid;
    logic              digest_ack;
    logic              busy;
    logic              error;
    logic [7:0]        block_cnt;

    // Handshake: a word moves on every rising edge where msg_valid && msg_ready;
    // msg_ready is high only in LOAD, and the word is strobed (load_en) in that cycle.
    modport master (
        output start, msg_valid, msg_data, msg_last, core_complete, digest_ack,
        input  msg_ready, load_en, load_data, core_init, core_enable,
               digest_valid, busy, error, block_cnt
    );

    modport slave (
        input  start, msg_valid, msg_data, msg_last, core_complete, digest_ack,
        output msg_ready, load_en, load_data, core_init, core_enable,
               digest_valid, busy, error, block_cnt
    );
endinterface

// File: rtl/sha3_sequencer.sv
// Sequences padded host words into 1088-bit rate blocks and drives the
// Keccak round core through load / run / digest phases with a run timeout.
module sha3_sequencer #(
    parameter int WORD_W          = 136,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ROUND_TIMEOUT   = 63
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    sha3_sequencer_if.slave   bus,
    output logic [2:0]        state_o
);
    localparam int WCW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int TCW = (ROUND_TIMEOUT > 0) ? $clog2(ROUND_TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_BLOCK - 1);
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(ROUND_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           last_flag_q, last_flag_d;
    logic [7:0]     block_cnt_q, block_cnt_d;
    logic           core_enable_q, digest_valid_q, busy_q, error_q;

    logic accept;
    logic restart;

    assign accept  = (state_q == LOAD) && bus.msg_valid;
    assign restart = bus.start && ((state_q == IDLE) || (state_q == ERR));

    assign bus.msg_ready    = (state_q == LOAD);
    assign bus.load_en      = accept;
    assign bus.load_data    = accept ? bus.msg_data : '0;
    // Gated by reset so a start held during reset cannot leak an init pulse.
    assign bus.core_init    = reset_ni && restart;
    assign bus.core_enable  = core_enable_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.busy         = busy_q;
    assign bus.error        = error_q;
    assign bus.block_cnt    = block_cnt_q;
    assign state_o          = state_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        tmo_d       = tmo_q;
        last_flag_d = last_flag_q;
        block_cnt_d = block_cnt_q;
        case (state_q)
            IDLE, ERR: begin
                if (bus.start) begin
                    state_d     = LOAD;
                    word_cnt_d  = '0;
                    block_cnt_d = '0;
                    last_flag_d = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d  = '0;
                        last_flag_d = bus.msg_last;
                        tmo_d       = '0;
                        state_d     = RUN;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                        if (bus.msg_last) state_d = ERR;
                    end
                end
            end
            RUN: begin
                tmo_d = tmo_q + TCW'(1);
                // Completion on the final allowed cycle takes priority over the timeout.
                if (bus.core_complete) begin
                    block_cnt_d = (block_cnt_q == 8'hFF) ? 8'hFF : block_cnt_q + 8'd1;
                    state_d     = last_flag_q ? DONE : LOAD;
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                if (bus.digest_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= IDLE;
            word_cnt_q     <= '0;
            tmo_q          <= '0;
            last_flag_q    <= 1'b0;
            block_cnt_q    <= '0;
            core_enable_q  <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            tmo_q          <= tmo_d;
            last_flag_q    <= last_flag_d;
            block_cnt_q    <= block_cnt_d;
            // Registered status outputs follow the next state so they line up with it.
            core_enable_q  <= (state_d == RUN);
            digest_valid_q <= (state_d == DONE);
            busy_q         <= (state_d != IDLE);
            error_q        <= (state_d == ERR);
        end
    end
endmodule

// File: tb/tb_sha3_sequencer.sv
// Directed-random bench for sha3_sequencer: host driver, round-core stand-in,
// load_data scoreboard and message-level reference model.
module tb_sha3_sequencer;
  localparam int W   = 136;
  localparam int WPB = 8;
  localparam int TMO = 63;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic [2:0] state;

  sha3_sequencer_if #(.WORD_W(W)) bus ();

  sha3_sequencer #(
    .WORD_W(W), .WORDS_PER_BLOCK(WPB), .ROUND_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .bus(bus), .state_o(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_load = 0;
  int n_init = 0;
  int n_run = 0;
  logic prev_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  // Monitor: records strobed words and counts init pulses / RUN periods.
  always @(negedge clk) begin
    if (bus.load_en) begin
      obs_q.push_back(bus.load_data);
      n_load++;
    end
    if (bus.core_init) n_init++;
    if (bus.core_enable && !prev_en) n_run++;
    prev_en = bus.core_enable;
  end

  // Reference model: a message of n words with msg_last on word n.
  function automatic int model_blocks(input int n);
    int b;
    b = n / WPB;
    return (b > 255) ? 255 : b;
  endfunction

  function automatic bit model_err(input int n);
    return (n % WPB) != 0;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] data, input bit last);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    bus.msg_valid = 1'b1;
    bus.msg_data  = data;
    bus.msg_last  = last;
    exp_q.push_back(data);
    do begin
      @(negedge clk);
      ok = bus.msg_ready;
      tick();
      guard++;
    end while (!ok && guard < 20);
    if (!ok) check("ready_timeout", ok, 1);
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.msg_data  = '0;
  endtask

  // Stand-in round core: complete after delay RUN cycles; start optionally toggled meanwhile.
  task automatic run_core(input int delay, input bit noisy);
    repeat (delay) begin
      if (noisy) bus.start = 1'($urandom_range(0, 1));
      tick();
      bus.start = 1'b0;
    end
    bus.core_complete = 1'b1;
    check("pre_digest_low", bus.digest_valid, 0);
    tick();
    bus.core_complete = 1'b0;
    check("enable_drop", bus.core_enable, 0);
  endtask

  task automatic begin_msg();
    bus.start = 1'b1;
    @(negedge clk);
    check("init_pulse", bus.core_init, 1);
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("ready_after_start", bus.msg_ready, 1);
    check("blk_cleared", bus.block_cnt, 0);
  endtask

  task automatic send_msg(input int n, input int delay, input bit noisy);
    for (int i = 0; i < n; i++) begin
      int st;
      st = $urandom_range(0, 2);
      repeat (st) begin
        if (noisy) begin
          bus.start = 1'b1;
          bus.digest_ack = 1'b1;
          bus.core_complete = 1'b1;
        end
        tick();
        bus.start = 1'b0;
        bus.digest_ack = 1'b0;
        bus.core_complete = 1'b0;
      end
      send_word(rand_word(), i == n - 1);
      if ((i + 1) % WPB == 0) begin
        check("run_latency", bus.core_enable, 1);
        run_core(delay, noisy);
        if (i != n - 1) check("back_to_load", bus.msg_ready, 1);
      end
    end
  endtask

  task automatic finish_msg(input int blocks);
    int st;
    check("digest_valid", bus.digest_valid, 1);
    check("block_cnt", bus.block_cnt, blocks);
    st = $urandom_range(0, 2);
    repeat (st) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("digest_hold", bus.digest_valid, 1);
    end
    bus.digest_ack = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
    check("digest_clear", bus.digest_valid, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      if (obs_q.size() == 0) begin
        check("load_missing", obs_q.size(), exp_q.size());
        exp_q.delete();
      end else begin
        check("load_data", obs_q.pop_front(), exp_q.pop_front());
      end
    end
    check("load_extra", obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    int l0, i0, r0, n, d;
    bus.start = 1'b0; bus.msg_valid = 1'b0; bus.msg_data = '0; bus.msg_last = 1'b0;
    bus.core_complete = 1'b0; bus.digest_ack = 1'b0;

    // Reset: all outputs low, even with start held.
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_msg_ready", bus.msg_ready, 0);
    check("rst_load_en", bus.load_en, 0);
    check("rst_load_data", bus.load_data, 0);
    check("rst_core_init", bus.core_init, 0);
    check("rst_core_enable", bus.core_enable, 0);
    check("rst_digest_valid", bus.digest_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_error", bus.error, 0);
    check("rst_block_cnt", bus.block_cnt, 0);
    bus.start = 1'b0;
    tick();
    reset_ni = 1'b1;
    tick();
    check("idle_after_rst", bus.busy, 0);

    // Single block, complete 24 cycles into RUN.
    l0 = n_load; i0 = n_init; r0 = n_run;
    begin_msg();
    send_msg(8, 24, 1'b0);
    finish_msg(model_blocks(8));
    check("single_loads", n_load - l0, 8);
    check("single_runs", n_run - r0, 1);
    check("single_inits", n_init - i0, 1);
    drain();

    // Three blocks with host stalls and ignored start/ack/complete noise.
    l0 = n_load; i0 = n_init; r0 = n_run;
    n = 3 * WPB;
    d = $urandom_range(1, 30);
    begin_msg();
    send_msg(n, d, 1'b1);
    finish_msg(model_blocks(n));
    check("multi_loads", n_load - l0, n);
    check("multi_runs", n_run - r0, model_blocks(n));
    check("multi_inits", n_init - i0, 1);
    drain();

    // Early msg_last on word 5 -> error, then recovery with start.
    l0 = n_load; i0 = n_init; r0 = n_run;
    n = 5;
    begin_msg();
    send_msg(n, 1, 1'b0);
    check("early_error", bus.error, model_err(n));
    check("early_ready", bus.msg_ready, 0);
    check("early_enable", bus.core_enable, 0);
    check("early_loads", n_load - l0, n);
    check("early_runs", n_run - r0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    check("err_init_pulse", bus.core_init, 1);
    tick();
    bus.start = 1'b0;
    check("err_cleared", bus.error, 0);
    check("err_to_load", bus.msg_ready, 1);
    send_msg(8, 10, 1'b0);
    finish_msg(model_blocks(8));
    drain();

    // Timeout: complete withheld for ROUND_TIMEOUT+1 RUN cycles.
    begin_msg();
    for (int i = 0; i < WPB; i++) send_word(rand_word(), i == WPB - 1);
    repeat (TMO) tick();
    check("tmo_not_yet", bus.error, 0);
    check("tmo_still_run", bus.core_enable, 1);
    tick();
    check("tmo_error", bus.error, 1);
    check("tmo_enable_off", bus.core_enable, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < WPB; i++) send_word(rand_word(), i == WPB - 1);
    repeat (TMO) tick();
    bus.core_complete = 1'b1;
    tick();
    bus.core_complete = 1'b0;
    check("tmo_edge_no_error", bus.error, 0);
    finish_msg(1);
    drain();

    // Asynchronous reset in the middle of block 2's RUN.
    begin_msg();
    for (int i = 0; i < WPB; i++) send_word(rand_word(), 1'b0);
    run_core(5, 1'b0);
    for (int i = 0; i < WPB; i++) send_word(rand_word(), i == WPB - 1);
    repeat (3) tick();
    i0 = n_init;
    #3;
    reset_ni = 1'b0;
    #1;
    check("arst_enable", bus.core_enable, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_block_cnt", bus.block_cnt, 0);
    check("arst_ready", bus.msg_ready, 0);
    tick();
    reset_ni = 1'b1;
    repeat (3) tick();
    check("arst_idle", bus.busy, 0);
    check("arst_no_init", n_init - i0, 0);
    drain();
    begin_msg();
    send_msg(8, 3, 1'b0);
    finish_msg(1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha3_sequencer.md
SHA3_SEQUENCER -- requirements
Module: sha3_sequencer

Interface
REQ-001 Parameter WORD_W, default 136: width of one message word (one scan slice of the 1088-bit rate block).
REQ-002 Parameter WORDS_PER_BLOCK, default 8: words per 1088-bit block.
REQ-003 Parameter ROUND_TIMEOUT, default 63: maximum RUN cycles before core_complete must arrive.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a new message.
REQ-007 msg_valid  input  1  host word valid.
REQ-008 msg_data  input  WORD_W  host word, already padded by the host.
REQ-009 msg_last  input  1  marks the final word of the final block.
REQ-010 msg_ready  output  1  sequencer accepts a word this cycle.
REQ-011 load_en  output  1  strobe: write load_data into the input buffer.
REQ-012 load_data  output  WORD_W  word forwarded to the input buffer.
REQ-013 core_init  output  1  one-cycle pulse clearing the permutation state and round counter.
REQ-014 core_enable  output  1  enable to the round core.
REQ-015 core_complete  input  1  round core has finished all 24 rounds for the current block.
REQ-016 digest_valid  output  1  256-bit digest on the core output is final.
REQ-017 digest_ack  input  1  host has consumed the digest.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 error  output  1  sticky protocol/timeout error.
REQ-020 block_cnt  output  8  blocks absorbed in the current message, saturating at 255.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN, DONE, ERR.
REQ-022 IDLE: start=1 -> core_init=1 for exactly that cycle, word_cnt=0, block_cnt=0, next state LOAD; other inputs ignored.
REQ-023 LOAD: msg_ready=1 combinationally; a word SHALL be accepted iff msg_valid&&msg_ready.
REQ-024 On acceptance: load_en=1 in the same cycle, load_data=msg_data (combinational pass-through), word_cnt increments; load_en=0 in all other cycles.
REQ-025 Acceptance with word_cnt==WORDS_PER_BLOCK-1: latch last_flag=msg_last, word_cnt wraps to 0, next state RUN.
REQ-026 Acceptance with msg_last=1 and word_cnt!=WORDS_PER_BLOCK-1: word still strobed, next state ERR.
REQ-027 RUN: msg_ready=0, core_enable=1, timeout counter increments each cycle from 0 on entry.
REQ-028 core_complete SHALL be sampled only in RUN; ignored in every other state.
REQ-029 RUN with core_complete=1: block_cnt increments (saturating), core_enable=0 from the next cycle, next state DONE if last_flag else LOAD; core state retained (no core_init).
REQ-030 RUN with timeout counter==ROUND_TIMEOUT and core_complete=0: next state ERR; complete in that same cycle wins (no error).
REQ-031 DONE: digest_valid=1 until digest_ack=1 sampled; then next state IDLE with digest_valid=0 from the next cycle.
REQ-032 ERR: error=1, core_enable=0, msg_ready=0; held until start=1, which clears error, pulses core_init and enters LOAD.
REQ-033 start in LOAD, RUN or DONE SHALL be ignored.
REQ-034 digest_ack outside DONE SHALL be ignored.
REQ-035 Minimum latency: last word accepted at cycle N -> core_enable high at N+1; complete at cycle M -> digest_valid high at M+1.

Reset
REQ-036 reset=0 SHALL asynchronously force state IDLE, word_cnt=0, block_cnt=0, timeout counter 0, last_flag=0.
REQ-037 During and after reset all outputs SHALL be 0 (msg_ready, load_en, load_data, core_init, core_enable, digest_valid, busy, error, block_cnt).
REQ-038 Reset asserted mid-message SHALL abandon the message; no core_init pulse is generated by reset itself.

Verification
REQ-039 Single block: start, 8 words with msg_last on word 8, core_complete 24 cycles later -> 8 load_en pulses, block_cnt=1, digest_valid at complete+1, IDLE after digest_ack.
REQ-040 Three blocks, host stalls msg_valid randomly -> 24 load_en pulses total, exactly 3 RUN periods, no core_init between blocks, block_cnt=3.
REQ-041 msg_last on word 5 of block 1 -> 5 load_en pulses, error=1 next cycle, core_enable never asserted; start then recovers to LOAD with error=0.
REQ-042 core_complete withheld in RUN -> error=1 after ROUND_TIMEOUT+1 RUN cycles; complete on the timeout cycle -> no error.
REQ-043 reset=0 asserted mid-RUN of block 2 -> all outputs 0 immediately (asynchronous), IDLE after release, start required to resume.
REQ-044 start pulsed during LOAD/RUN/DONE and digest_ack pulsed in LOAD -> no state change, no extra core_init.
